// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: loads take priority, ALU results queue in a FIFO,
// and a starvation counter forces one ALU drain slot. Optional stats: WB_ARB_STALL_STATS_EN.
module wb_port_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_waddr,
    input  logic [31:0]                  alu_wdata,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [4:0]                   mem_waddr,
    input  logic [31:0]                  mem_wdata,
    output logic                         mem_ready,
    output logic [1:0]                   we,
    output logic [4:0]                   waddr,
    output logic [31:0]                  wdata,
    output logic [31:0]                  wdata_from_ram,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
`ifdef WB_ARB_STALL_STATS_EN
    ,
    output logic [31:0]                  alu_stall_cnt,
    output logic [31:0]                  mem_stall_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_ALU  = 2'b01;
    localparam logic [1:0] WE_RAM  = 2'b10;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_beat_t;

    typedef enum logic {
        MEM_PRI   = 1'b0,
        ALU_FORCE = 1'b1
    } state_t;

    wb_beat_t        fifo_q [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    state_t          state_q;
    logic [SW-1:0]   starve_q;
    logic [1:0]      we_q;
    logic [4:0]      waddr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     wram_q;

    logic            fifo_full, fifo_empty;
    logic            mem_take, push, pop;
    wb_beat_t        head;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    assign alu_ready  = !fifo_full;
    assign mem_ready  = (state_q == MEM_PRI);

    // Full blocks a push even when this edge also pops.
    assign mem_take   = mem_valid && (state_q == MEM_PRI);
    assign push       = alu_valid && !fifo_full;
    assign pop        = !mem_take && !fifo_empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= '{addr: alu_waddr, data: alu_wdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Arbitration FSM with registered regfile outputs. Writes to r0 still consume
    // the beat and move waddr, but never assert a write select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MEM_PRI;
            starve_q <= '0;
            we_q     <= WE_NONE;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wram_q   <= '0;
        end else begin
            if (mem_take) begin
                we_q    <= (mem_waddr == 5'd0) ? WE_NONE : WE_RAM;
                waddr_q <= mem_waddr;
                wram_q  <= mem_wdata;
            end else if (!fifo_empty) begin
                we_q    <= (head.addr == 5'd0) ? WE_NONE : WE_ALU;
                waddr_q <= head.addr;
                wdata_q <= head.data;
            end else begin
                we_q    <= WE_NONE;
            end

            case (state_q)
                MEM_PRI: begin
                    if (fifo_empty || pop) begin
                        starve_q <= '0;
                    end else begin
                        starve_q <= starve_q + SW'(1);
                        if (starve_q + SW'(1) == SW'(STARVE_LIMIT))
                            state_q <= ALU_FORCE;
                    end
                end
                ALU_FORCE: begin
                    starve_q <= '0;
                    state_q  <= MEM_PRI;
                end
                default: begin
                    starve_q <= '0;
                    state_q  <= MEM_PRI;
                end
            endcase
        end
    end

    assign we             = we_q;
    assign waddr          = waddr_q;
    assign wdata          = wdata_q;
    assign wdata_from_ram = wram_q;
    assign fifo_count     = count_q;

`ifdef WB_ARB_STALL_STATS_EN
    logic [31:0] alu_stall_q, mem_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_stall_q <= '0;
            mem_stall_q <= '0;
        end else begin
            if (alu_valid && !alu_ready && alu_stall_q != 32'hFFFF_FFFF)
                alu_stall_q <= alu_stall_q + 32'd1;
            if (mem_valid && !mem_ready && mem_stall_q != 32'hFFFF_FFFF)
                mem_stall_q <= mem_stall_q + 32'd1;
        end
    end

    assign alu_stall_cnt = alu_stall_q;
    assign mem_stall_cnt = mem_stall_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed vector bench for wb_port_arbiter: per-cycle table plus a streaming sequence.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [1:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] wdata_from_ram;
    logic [2:0]  fifo_count;
`ifdef WB_ARB_STALL_STATS_EN
    logic [31:0] alu_stall_cnt;
    logic [31:0] mem_stall_cnt;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .wdata_from_ram(wdata_from_ram),
        .fifo_count(fifo_count)
`ifdef WB_ARB_STALL_STATS_EN
        , .alu_stall_cnt(alu_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        chk_bus;
        logic [1:0]  we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] wr;
        logic [2:0]  cnt;
        logic        ar;
        logic        mr;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input int r, input int av, input int aa, input int ad,
                       input int mv, input int ma, input int md, input int cb,
                       input int ewe, input int ewa, input int ewd, input int ewr,
                       input int ecnt, input int ear, input int emr);
        vec_t v;
        v.rst = 1'(r);   v.av = 1'(av); v.aa = 5'(aa); v.ad = 32'(ad);
        v.mv  = 1'(mv);  v.ma = 5'(ma); v.md = 32'(md); v.chk_bus = 1'(cb);
        v.we  = 2'(ewe); v.wa = 5'(ewa); v.wd = 32'(ewd); v.wr = 32'(ewr);
        v.cnt = 3'(ecnt); v.ar = 1'(ear); v.mr = 1'(emr);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        alu_valid = v.av; alu_waddr = v.aa; alu_wdata = v.ad;
        mem_valid = v.mv; mem_waddr = v.ma; mem_wdata = v.md;
    endtask

    task automatic check_outputs(input vec_t v, input int idx);
        chk("we", idx, 32'(we), 32'(v.we));
        chk("waddr", idx, 32'(waddr), 32'(v.wa));
        chk("fifo_count", idx, 32'(fifo_count), 32'(v.cnt));
        chk("alu_ready", idx, 32'(alu_ready), 32'(v.ar));
        chk("mem_ready", idx, 32'(mem_ready), 32'(v.mr));
        if (v.chk_bus) begin
            chk("wdata", idx, wdata, v.wd);
            chk("wdata_from_ram", idx, wdata_from_ram, v.wr);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0;

        //  rst av aa ad            mv ma md    cb  we wa wd            wr     cnt ar mr
        // reset state
        add(1, 0, 0, 0,            0, 0, 0,     1,  0, 0, 0,            0,     0, 1, 1);
        // single ALU beat
        add(0, 1, 5, 'h12345678,   0, 0, 0,     1,  0, 0, 0,            0,     1, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  1, 5, 'h12345678,   0,     0, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  0, 5, 'h12345678,   0,     0, 1, 1);
        // simultaneous ALU + load: load first
        add(0, 1, 3, 'hA,          1, 4, 'hB,   1,  2, 4, 'h12345678,   'hB,   1, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  1, 3, 'hA,          'hB,   0, 1, 1);
        // fill FIFO under loads, forced drain, held 5th beat, ordered drain
        add(0, 1, 11, 'hA1,        1, 10, 'h101, 1, 2, 10, 'hA,         'h101, 1, 1, 1);
        add(0, 1, 12, 'hA2,        1, 10, 'h102, 1, 2, 10, 'hA,         'h102, 2, 1, 1);
        add(0, 1, 13, 'hA3,        1, 10, 'h103, 1, 2, 10, 'hA,         'h103, 3, 1, 1);
        add(0, 1, 14, 'hA4,        1, 10, 'h104, 1, 2, 10, 'hA,         'h104, 4, 0, 0);
        add(0, 1, 15, 'hA5,        1, 10, 'h105, 1, 1, 11, 'hA1,        'h104, 3, 1, 1);
        add(0, 1, 15, 'hA5,        1, 10, 'h105, 1, 2, 10, 'hA1,        'h105, 4, 0, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  1, 12, 'hA2,        'h105, 3, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  1, 13, 'hA3,        'h105, 2, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  1, 14, 'hA4,        'h105, 1, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  1, 15, 'hA5,        'h105, 0, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  0, 15, 'hA5,        'h105, 0, 1, 1);
        // continuous loads with two queued ALU results: starvation forcing
        add(0, 1, 21, 'hC1,        1, 20, 'h201, 1, 2, 20, 'hA5,        'h201, 1, 1, 1);
        add(0, 1, 22, 'hC2,        1, 20, 'h202, 1, 2, 20, 'hA5,        'h202, 2, 1, 1);
        add(0, 0, 0, 0,            1, 20, 'h203, 1, 2, 20, 'hA5,        'h203, 2, 1, 1);
        add(0, 0, 0, 0,            1, 20, 'h204, 1, 2, 20, 'hA5,        'h204, 2, 1, 0);
        add(0, 0, 0, 0,            1, 20, 'h205, 1, 1, 21, 'hC1,        'h204, 1, 1, 1);
        add(0, 0, 0, 0,            1, 20, 'h205, 1, 2, 20, 'hC1,        'h205, 1, 1, 1);
        add(0, 0, 0, 0,            1, 20, 'h206, 1, 2, 20, 'hC1,        'h206, 1, 1, 1);
        add(0, 0, 0, 0,            1, 20, 'h207, 1, 2, 20, 'hC1,        'h207, 1, 1, 0);
        add(0, 0, 0, 0,            1, 20, 'h208, 1, 1, 22, 'hC2,        'h207, 0, 1, 1);
        add(0, 0, 0, 0,            1, 20, 'h208, 1, 2, 20, 'hC2,        'h208, 0, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  0, 20, 'hC2,        'h208, 0, 1, 1);
        // register 0: consumed, waddr moves, no write select
        add(0, 1, 0, 'hDEAD,       0, 0, 0,     1,  0, 20, 'hC2,        'h208, 1, 1, 1);
        add(0, 1, 7, 'h77,         0, 0, 0,     0,  0, 0, 0,            0,     1, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  1, 7, 'h77,         'h208, 0, 1, 1);
        add(0, 0, 0, 0,            1, 0, 'h300, 0,  0, 0, 0,            0,     0, 1, 1);
        add(0, 0, 0, 0,            1, 9, 'h301, 1,  2, 9, 'h77,         'h301, 0, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  0, 9, 'h77,         'h301, 0, 1, 1);
        // three queued entries, then reset while in ALU_FORCE
        add(0, 1, 1, 'hE1,         1, 2, 'hF1,  1,  2, 2, 'h77,         'hF1,  1, 1, 1);
        add(0, 1, 1, 'hE2,         1, 2, 'hF2,  1,  2, 2, 'h77,         'hF2,  2, 1, 1);
        add(0, 1, 1, 'hE3,         1, 2, 'hF3,  1,  2, 2, 'h77,         'hF3,  3, 1, 1);
        add(0, 0, 0, 0,            1, 2, 'hF4,  1,  2, 2, 'h77,         'hF4,  3, 1, 0);
        add(1, 0, 0, 0,            0, 0, 0,     1,  0, 0, 0,            0,     0, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  0, 0, 0,            0,     0, 1, 1);
        add(0, 0, 0, 0,            0, 0, 0,     1,  0, 0, 0,            0,     0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_outputs(vecs[i], i);
        end

        // Back-to-back ALU stream with no loads: push and pop share each edge,
        // occupancy stays at 1 and results leave in order one cycle behind.
        for (int k = 0; k <= 6; k++) begin
            rst = 1'b0;
            mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0;
            alu_valid = (k < 6);
            alu_waddr = 5'(k + 1);
            alu_wdata = 32'h500 + 32'(k);
            @(posedge clk);
            #1;
            if (k == 0) begin
                chk("stream_we", 100 + k, 32'(we), 32'd0);
            end else begin
                chk("stream_we", 100 + k, 32'(we), 32'd1);
                chk("stream_waddr", 100 + k, 32'(waddr), 32'(k));
                chk("stream_wdata", 100 + k, wdata, 32'h500 + 32'(k - 1));
            end
            chk("stream_count", 100 + k, 32'(fifo_count), (k < 6) ? 32'd1 : 32'd0);
        end

        alu_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stream_idle_we", 200, 32'(we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
